// File: rtl/mac_pkg.sv
// Constants and state encoding shared by the operand sequencer and the MAC stage.
package mac_pkg;

  localparam int MAC_DATA_W   = 32;
  localparam int MAC_LEN_W    = 16;
  localparam int MAC_MULT_LAT = 3;
  localparam int MAC_ADD_LAT  = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    FINAL  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Command, operand-stream and MAC-drive signals of the operand sequencer.
interface mac_operand_sequencer_if
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int LEN_W  = MAC_LEN_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              abort;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              mac_clr;
  logic              mac_en;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic              mac_finalize;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_len, abort, op_valid, op_a, op_b,
    input  cmd_ready, op_ready, mac_clr, mac_en, mac_a, mac_b, mac_finalize, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_len, abort, op_valid, op_a, op_b,
    output cmd_ready, op_ready, mac_clr, mac_en, mac_a, mac_b, mac_finalize, busy, done
  );

endinterface

// File: rtl/mac_operand_sequencer.sv
// Feeds a dot-product command into the MAC: clear, stream operand pairs, wait out the
// pipeline, then finalize once the last product has reached the accumulator.
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_W   = MAC_DATA_W,
  parameter int LEN_W    = MAC_LEN_W,
  parameter int MULT_LAT = MAC_MULT_LAT,
  parameter int ADD_LAT  = MAC_ADD_LAT
) (
  input logic                   clk,
  input logic                   rst_n,
  mac_operand_sequencer_if.slave bus
);

  localparam int DRAIN_D = MULT_LAT + ADD_LAT;
  localparam int DRAIN_W = $clog2(DRAIN_D + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_D);

  seq_state_t        state_r;
  logic [LEN_W-1:0]  remaining_r;
  logic [DRAIN_W-1:0] drain_cnt_r;
  logic              mac_clr_r;
  logic              mac_en_r;
  logic              mac_finalize_r;
  logic              done_r;
  logic [DATA_W-1:0] mac_a_r;
  logic [DATA_W-1:0] mac_b_r;
  logic              cmd_fire_s;
  logic              op_fire_s;

  // Ready terms are gated by abort so an aborted cycle never consumes a transfer.
  always_comb begin
    bus.cmd_ready = (state_r == IDLE) && !bus.abort;
    bus.op_ready  = (state_r == STREAM) && !bus.abort;
    cmd_fire_s    = bus.cmd_valid && bus.cmd_ready;
    op_fire_s     = bus.op_valid && bus.op_ready;
  end

  assign bus.mac_clr      = mac_clr_r;
  assign bus.mac_en       = mac_en_r;
  assign bus.mac_a        = mac_a_r;
  assign bus.mac_b        = mac_b_r;
  assign bus.mac_finalize = mac_finalize_r;
  assign bus.done         = done_r;
  assign bus.busy         = (state_r != IDLE);

  // Sequencer FSM with its remaining/drain counters and registered MAC controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      remaining_r    <= '0;
      drain_cnt_r    <= '0;
      mac_clr_r      <= 1'b0;
      mac_en_r       <= 1'b0;
      mac_finalize_r <= 1'b0;
      done_r         <= 1'b0;
      mac_a_r        <= '0;
      mac_b_r        <= '0;
    end else begin
      mac_clr_r      <= 1'b0;
      mac_en_r       <= 1'b0;
      mac_finalize_r <= 1'b0;
      done_r         <= 1'b0;
      if ((state_r != IDLE) && bus.abort) begin
        state_r     <= IDLE;
        remaining_r <= '0;
        drain_cnt_r <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            if (cmd_fire_s) begin
              remaining_r <= bus.cmd_len;
              mac_clr_r   <= 1'b1;
              state_r     <= CLEAR;
            end else begin
              state_r <= IDLE;
            end
          end
          CLEAR: begin
            drain_cnt_r <= '0;
            if (remaining_r == '0) begin
              mac_finalize_r <= 1'b1;
              done_r         <= 1'b1;
              state_r        <= FINAL;
            end else begin
              state_r <= STREAM;
            end
          end
          STREAM: begin
            if (op_fire_s) begin
              mac_en_r    <= 1'b1;
              mac_a_r     <= bus.op_a;
              mac_b_r     <= bus.op_b;
              remaining_r <= remaining_r - LEN_W'(1);
              if (remaining_r == LEN_W'(1)) begin
                drain_cnt_r <= '0;
                state_r     <= DRAIN;
              end else begin
                state_r <= STREAM;
              end
            end else begin
              state_r <= STREAM;
            end
          end
          DRAIN: begin
            // Counting from the cycle of the last mac_en lands finalize exactly D+1 later.
            if (drain_cnt_r == DRAIN_LAST) begin
              mac_finalize_r <= 1'b1;
              done_r         <= 1'b1;
              state_r        <= FINAL;
            end else begin
              drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
              state_r     <= DRAIN;
            end
          end
          FINAL: begin
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed cycle-by-cycle bench for mac_operand_sequencer with hand-computed expectations.
module tb_mac_operand_sequencer;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  // Flag order: {cmd_ready, op_ready, mac_clr, mac_en, mac_finalize, done, busy}
  localparam logic [6:0] F_IDLE   = 7'b1000000;
  localparam logic [6:0] F_CLR    = 7'b0010001;
  localparam logic [6:0] F_STR    = 7'b0100001;
  localparam logic [6:0] F_STR_EN = 7'b0101001;
  localparam logic [6:0] F_DR_EN  = 7'b0001001;
  localparam logic [6:0] F_DR     = 7'b0000001;
  localparam logic [6:0] F_FIN    = 7'b0000111;

  mac_operand_sequencer_if #(.DATA_W(32), .LEN_W(16)) bus ();

  mac_operand_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt = vec_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] flags();
    return {bus.cmd_ready, bus.op_ready, bus.mac_clr, bus.mac_en,
            bus.mac_finalize, bus.done, bus.busy};
  endfunction

  task automatic check_out(input string tag, input logic [6:0] ef,
                           input logic [31:0] ea, input logic [31:0] eb);
    chk({tag, "_flags"}, 64'(flags()), 64'(ef));
    chk({tag, "_a"}, 64'(bus.mac_a), 64'(ea));
    chk({tag, "_b"}, 64'(bus.mac_b), 64'(eb));
  endtask

  // Entered 2 ns after a rising edge: drive this cycle's inputs, check, advance one cycle.
  task automatic cyc(input string tag, input logic cv, input logic [15:0] len,
                     input logic ab, input logic ov, input logic [31:0] a,
                     input logic [31:0] b, input logic [6:0] ef,
                     input logic [31:0] ea, input logic [31:0] eb);
    bus.cmd_valid = cv;
    bus.cmd_len   = len;
    bus.abort     = ab;
    bus.op_valid  = ov;
    bus.op_a      = a;
    bus.op_b      = b;
    #2;
    check_out(tag, ef, ea, eb);
    @(posedge clk);
    #2;
  endtask

  task automatic idl(input string tag, input logic [6:0] ef,
                     input logic [31:0] ea, input logic [31:0] eb);
    cyc(tag, 1'b0, 16'd0, 1'b0, 1'b0, 32'd0, 32'd0, ef, ea, eb);
  endtask

  task automatic cmd(input string tag, input logic [15:0] len, input logic [6:0] ef,
                     input logic [31:0] ea, input logic [31:0] eb);
    cyc(tag, 1'b1, len, 1'b0, 1'b0, 32'd0, 32'd0, ef, ea, eb);
  endtask

  task automatic opc(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [6:0] ef, input logic [31:0] ea, input logic [31:0] eb);
    cyc(tag, 1'b0, 16'd0, 1'b0, 1'b1, a, b, ef, ea, eb);
  endtask

  // Directed scenarios.
  initial begin
    vec_cnt       = 0;
    err_cnt       = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = 16'd0;
    bus.abort     = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    @(posedge clk);
    #2;
    check_out("reset", F_IDLE, 32'd0, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // 1: len=3 back-to-back; last mac_en at T, finalize at T+5, cmd_ready at T+6
    cmd("t1_cmd", 16'd3, F_IDLE, 32'd0, 32'd0);
    opc("t1_clear", 32'd1, 32'd2, F_CLR, 32'd0, 32'd0);
    opc("t1_op1", 32'd1, 32'd2, F_STR, 32'd0, 32'd0);
    opc("t1_op2", 32'd3, 32'd4, F_STR_EN, 32'd1, 32'd2);
    opc("t1_op3", 32'd5, 32'd6, F_STR_EN, 32'd3, 32'd4);
    idl("t1_last_en", F_DR_EN, 32'd5, 32'd6);
    for (int i = 0; i < 4; i++) idl("t1_drain", F_DR, 32'd5, 32'd6);
    idl("t1_final", F_FIN, 32'd5, 32'd6);
    idl("t1_idle", F_IDLE, 32'd5, 32'd6);

    // 2: len=3 with a 2-cycle bubble after pair 1; mac_a/b hold through the gap
    cmd("t2_cmd", 16'd3, F_IDLE, 32'd5, 32'd6);
    idl("t2_clear", F_CLR, 32'd5, 32'd6);
    opc("t2_op1", 32'd7, 32'd8, F_STR, 32'd5, 32'd6);
    idl("t2_gap1", F_STR_EN, 32'd7, 32'd8);
    idl("t2_gap2", F_STR, 32'd7, 32'd8);
    opc("t2_op2", 32'd9, 32'd10, F_STR, 32'd7, 32'd8);
    opc("t2_op3", 32'd11, 32'd12, F_STR_EN, 32'd9, 32'd10);
    idl("t2_last_en", F_DR_EN, 32'd11, 32'd12);
    for (int i = 0; i < 4; i++) idl("t2_drain", F_DR, 32'd11, 32'd12);
    idl("t2_final", F_FIN, 32'd11, 32'd12);
    idl("t2_idle", F_IDLE, 32'd11, 32'd12);

    // 3: len=0 -> clear then finalize; operands offered but never accepted
    cmd("t3_cmd", 16'd0, F_IDLE, 32'd11, 32'd12);
    opc("t3_clear", 32'd99, 32'd98, F_CLR, 32'd11, 32'd12);
    opc("t3_final", 32'd99, 32'd98, F_FIN, 32'd11, 32'd12);
    idl("t3_idle", F_IDLE, 32'd11, 32'd12);

    // 4: a len=1 command held valid through a len=2 command, taken the cycle after done
    cmd("t4_cmd", 16'd2, F_IDLE, 32'd11, 32'd12);
    cyc("t4_clear", 1'b1, 16'd1, 1'b0, 1'b0, 32'd0, 32'd0, F_CLR, 32'd11, 32'd12);
    cyc("t4_op1", 1'b1, 16'd1, 1'b0, 1'b1, 32'd2, 32'd3, F_STR, 32'd11, 32'd12);
    cyc("t4_op2", 1'b1, 16'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd4, F_STR_EN, 32'd2, 32'd3);
    cyc("t4_last_en", 1'b1, 16'd1, 1'b0, 1'b0, 32'd0, 32'd0, F_DR_EN, 32'hFFFF_FFFF, 32'd4);
    for (int i = 0; i < 4; i++)
      cyc("t4_drain", 1'b1, 16'd1, 1'b0, 1'b0, 32'd0, 32'd0, F_DR, 32'hFFFF_FFFF, 32'd4);
    cyc("t4_final", 1'b1, 16'd1, 1'b0, 1'b0, 32'd0, 32'd0, F_FIN, 32'hFFFF_FFFF, 32'd4);
    cmd("t4_cmd2", 16'd1, F_IDLE, 32'hFFFF_FFFF, 32'd4);
    idl("t4_clear2", F_CLR, 32'hFFFF_FFFF, 32'd4);
    opc("t4_op3", 32'd5, 32'd5, F_STR, 32'hFFFF_FFFF, 32'd4);
    idl("t4_last_en2", F_DR_EN, 32'd5, 32'd5);
    for (int i = 0; i < 4; i++) idl("t4_drain2", F_DR, 32'd5, 32'd5);
    idl("t4_final2", F_FIN, 32'd5, 32'd5);
    idl("t4_idle", F_IDLE, 32'd5, 32'd5);

    // 5: abort in DRAIN of len=4 suppresses finalize; a len=1 command then completes
    cmd("t5_cmd", 16'd4, F_IDLE, 32'd5, 32'd5);
    idl("t5_clear", F_CLR, 32'd5, 32'd5);
    opc("t5_op1", 32'd1, 32'd1, F_STR, 32'd5, 32'd5);
    opc("t5_op2", 32'd2, 32'd2, F_STR_EN, 32'd1, 32'd1);
    opc("t5_op3", 32'd3, 32'd3, F_STR_EN, 32'd2, 32'd2);
    opc("t5_op4", 32'd4, 32'd4, F_STR_EN, 32'd3, 32'd3);
    idl("t5_last_en", F_DR_EN, 32'd4, 32'd4);
    idl("t5_drain", F_DR, 32'd4, 32'd4);
    cyc("t5_abort", 1'b0, 16'd0, 1'b1, 1'b0, 32'd0, 32'd0, F_DR, 32'd4, 32'd4);
    idl("t5_aborted", F_IDLE, 32'd4, 32'd4);
    cmd("t5_cmd2", 16'd1, F_IDLE, 32'd4, 32'd4);
    idl("t5_clear2", F_CLR, 32'd4, 32'd4);
    opc("t5_op5", 32'd6, 32'd7, F_STR, 32'd4, 32'd4);
    idl("t5_last_en2", F_DR_EN, 32'd6, 32'd7);
    for (int i = 0; i < 4; i++) idl("t5_drain2", F_DR, 32'd6, 32'd7);
    idl("t5_final2", F_FIN, 32'd6, 32'd7);
    idl("t5_idle", F_IDLE, 32'd6, 32'd7);

    // 6: asynchronous reset mid-STREAM of a len=8 command after 3 pairs
    cmd("t6_cmd", 16'd8, F_IDLE, 32'd6, 32'd7);
    idl("t6_clear", F_CLR, 32'd6, 32'd7);
    opc("t6_op1", 32'd10, 32'd11, F_STR, 32'd6, 32'd7);
    opc("t6_op2", 32'd12, 32'd13, F_STR_EN, 32'd10, 32'd11);
    opc("t6_op3", 32'd14, 32'd15, F_STR_EN, 32'd12, 32'd13);
    bus.op_valid = 1'b0;
    #2;
    check_out("t6_pre_rst", F_STR_EN, 32'd14, 32'd15);
    #1;
    rst_n = 1'b0;
    #1;
    check_out("t6_async_rst", F_IDLE, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    check_out("t6_in_rst", F_IDLE, 32'd0, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    idl("t6_released", F_IDLE, 32'd0, 32'd0);
    idl("t6_still_idle", F_IDLE, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
